// File: rtl/crossbar_pkg.sv
// crossbar shared helpers.
// Selector width derivation for the event router.
package crossbar_pkg;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crossbar_mux.sv
// crossbar_mux: N_IN:1 one-bit selector.
// Selectors at or beyond N_IN yield 0.
module crossbar_mux #(
  parameter int N_IN = 32,
  parameter int W    = 5
) (
  input  logic [N_IN-1:0] vector_i,
  input  logic [W-1:0]    sel_i,
  output logic            event_o
);

  // Equality scan keeps an X selector from leaking into other lanes
  always_comb begin
    event_o = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == W'(i)) event_o = vector_i[i];
    end
  end

endmodule

// File: rtl/crossbar.sv
// crossbar: configurable event router.
// Each output registers its selected input event.
module crossbar
  import crossbar_pkg::*;
#(
  parameter  int N_OUT      = 24,
  parameter  int N_IN       = 32,
  localparam int N_BITS_CFG = sel_bits(N_IN)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  vector_i [0:N_IN-1],
  output logic                  vector_o [0:N_OUT-1],
  input  logic [N_BITS_CFG-1:0] cfg_i    [0:N_OUT-1]
);

  logic [N_IN-1:0]  vin;
  logic [N_OUT-1:0] sel;
  logic [N_OUT-1:0] q;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign vin[i] = vector_i[i];
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    crossbar_mux #(
      .N_IN (N_IN),
      .W    (N_BITS_CFG)
    ) u_mux (
      .vector_i (vin),
      .sel_i    (cfg_i[j]),
      .event_o  (sel[j])
    );
    assign vector_o[j] = q[j];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) q <= '0;
    else         q <= sel;
  end

endmodule

// File: tb/tb_crossbar.sv
// tb_crossbar: scoreboard bench for crossbar.
// Two instances: default 32x24 and a 20x4 non-power-of-2 build.
module tb_crossbar;

  localparam int NO  = 24;
  localparam int NI  = 32;
  localparam int NB  = 5;
  localparam int NO2 = 4;
  localparam int NI2 = 20;
  localparam int NB2 = 5;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic          vi   [0:NI-1];
  logic [NB-1:0] cfg  [0:NO-1];
  logic          vo   [0:NO-1];
  logic           vi2  [0:NI2-1];
  logic [NB2-1:0] cfg2 [0:NO2-1];
  logic           vo2  [0:NO2-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          inst;
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  crossbar #(.N_OUT(NO), .N_IN(NI)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .vector_i (vi),
    .vector_o (vo),
    .cfg_i    (cfg)
  );

  crossbar #(.N_OUT(NO2), .N_IN(NI2)) dut2 (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .vector_i (vi2),
    .vector_o (vo2),
    .cfg_i    (cfg2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pk1();
    logic [23:0] r;
    for (int j = 0; j < NO; j++) r[j] = vo[j];
    return r;
  endfunction

  function automatic logic [23:0] pk2();
    logic [23:0] r;
    r = '0;
    for (int j = 0; j < NO2; j++) r[j] = vo2[j];
    return r;
  endfunction

  task automatic chk(input string n, input logic [23:0] act,
                     input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic push(input string n, input int inst,
                      input logic [23:0] e, input int d);
    exp_t x;
    x.cyc  = cyc + d;
    x.inst = inst;
    x.exp  = e;
    x.name = n;
    sb.push_back(x);
  endtask

  task automatic set_vi(input logic [31:0] v);
    for (int i = 0; i < NI; i++) vi[i] = v[i];
  endtask

  task automatic set_cfg(input logic [NB-1:0] c);
    for (int j = 0; j < NO; j++) cfg[j] = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale entry due %0d at %0d", e.name, e.cyc, cyc);
      end else if (e.inst == 0) begin
        chk(e.name, pk1(), e.exp);
      end else begin
        chk(e.name, pk2(), e.exp);
      end
    end
  end

  initial begin
    logic [23:0] e;
    logic [31:0] oh;
    set_vi('1);
    set_cfg('0);
    for (int i = 0; i < NI2; i++) vi2[i] = 1'b1;
    for (int j = 0; j < NO2; j++) cfg2[j] = '0;

    // Reset with all inputs high
    #2 rstn = 1'b0;
    #1 chk("reset_async", pk1(), 24'h0);
    step();
    step();
    chk("reset_held", pk1(), 24'h0);
    chk("reset_held2", pk2(), 24'h0);
    rstn = 1'b1;
    push("reset_release", 0, 24'hFFFFFF, 1);
    push("reset_release2", 1, 24'h00000F, 1);
    step();

    // Exhaustive routing
    for (int in = 0; in < NI; in++) begin
      for (int o = 0; o < NO; o++) begin
        oh = 32'h1 << in;
        set_vi(oh);
        set_cfg('0);
        cfg[o] = NB'(in);
        e = (in == 0) ? 24'hFFFFFF : (24'h1 << o);
        push("route", 0, e, 1);
        step();
      end
    end

    // Latency and single-cycle pulse
    set_vi('0);
    set_cfg('0);
    cfg[5] = 5'd7;
    step();
    vi[7] = 1'b1;
    push("lat_before", 0, 24'h000000, 0);
    push("lat_after", 0, 24'h000020, 1);
    step();
    vi[7] = 1'b0;
    push("pulse_end", 0, 24'h000000, 1);
    step();

    // Fan-out
    set_cfg(5'd13);
    vi[13] = 1'b1;
    push("fanout_set", 0, 24'hFFFFFF, 1);
    step();
    vi[13] = 1'b0;
    push("fanout_clr", 0, 24'h000000, 1);
    step();

    // Mid-operation async reset
    set_cfg('0);
    cfg[0] = 5'd3;
    vi[3] = 1'b1;
    push("mid_route", 0, 24'h000001, 1);
    step();
    @(negedge clk);
    #1 rstn = 1'b0;
    #1 chk("mid_reset", pk1(), 24'h0);
    step();
    rstn = 1'b1;
    push("mid_recover", 0, 24'h000001, 1);
    step();

    // Non-power-of-2 selectors on the 20-input build
    cfg2[0] = 5'd25;
    push("np2_sel25", 1, 24'h00000E, 1);
    step();
    cfg2[0] = 5'd20;
    push("np2_sel20", 1, 24'h00000E, 1);
    step();
    cfg2[0] = 5'd19;
    vi2[19] = 1'b1;
    vi2[0] = 1'b0;
    push("np2_sel19", 1, 24'h000001, 1);
    step();
    cfg2[0] = 5'd31;
    push("np2_sel31", 1, 24'h000000, 1);
    step();

    for (int k = 0; k < 5 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
